// File: rtl/tx_pkt_source_pkg.sv
// Shared types and constants for the host-side packet source feeding the serial transmitter.
package tx_pkt_source_pkg;

    localparam int PKT_W = 55;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        BUSY   = 2'd2
    } tx_state_e;

    localparam tx_state_e RST_STATE = IDLE;
    localparam logic      RST_VALID = 1'b0;

endpackage

// File: rtl/tx_pkt_source_if.sv
// Core-side push handshake and transmitter-side launch handshake of tx_pkt_source.
interface tx_pkt_source_if
    import tx_pkt_source_pkg::*;
#(
    parameter int DATA_W = PKT_W
);
    logic [DATA_W-1:0] In_Data;
    logic              In_Valid;
    logic              In_Ready;
    logic              TX_Ready;
    logic [DATA_W-1:0] TX_Data;
    logic              TX_Data_Valid;

    // master is the packet source itself; slave is the core/transmitter side
    modport master (
        input  In_Data, In_Valid, TX_Ready,
        output In_Ready, TX_Data, TX_Data_Valid
    );

    modport slave (
        output In_Data, In_Valid, TX_Ready,
        input  In_Ready, TX_Data, TX_Data_Valid
    );
endinterface

// File: rtl/tx_pkt_source_pkt_fifo.sv
// Synchronous DEPTH x DATA_W FIFO with show-ahead head; pointers wrap naturally (power-of-2 depth).
module pkt_fifo
    import tx_pkt_source_pkg::*;
#(
    parameter int DATA_W = PKT_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    // a pop never frees room for a same-cycle push into a full FIFO
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/tx_pkt_source.sv
// Buffers router packets and launches them one at a time to the serial transmitter,
// holding TX_Data stable from launch until the transmitter returns to idle.
module tx_pkt_source
    import tx_pkt_source_pkg::*;
#(
    parameter int DATA_W = PKT_W,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2,
    parameter int CNT_W  = 16
) (
    input  logic                Clk_S,
    input  logic                Rst,
    tx_pkt_source_if.master     bus,
    output logic [ADDR_W:0]     Fifo_Count,
    output logic [CNT_W-1:0]    Pkts_Sent
);
    tx_state_e         state_q;
    tx_state_e         state_d;
    logic              pop;
    logic              sent_inc;
    logic              push;
    logic              full;
    logic              empty;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] tx_data_q;
    logic              tx_vld_q;

    assign bus.In_Ready      = !Rst && !full;
    assign push              = bus.In_Valid && bus.In_Ready;
    assign bus.TX_Data       = tx_data_q;
    assign bus.TX_Data_Valid = tx_vld_q;

    pkt_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .clk       (Clk_S),
        .rst       (Rst),
        .push      (push),
        .push_data (bus.In_Data),
        .pop       (pop),
        .head      (head),
        .count     (Fifo_Count),
        .full      (full),
        .empty     (empty)
    );

    always_comb begin
        state_d  = state_q;
        pop      = 1'b0;
        sent_inc = 1'b0;
        case (state_q)
            IDLE: begin
                if (!empty && bus.TX_Ready) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                // TX_Ready seen low means the transmitter has taken the packet
                if (!bus.TX_Ready) begin
                    sent_inc = 1'b1;
                    state_d  = BUSY;
                end
            end
            BUSY: begin
                if (bus.TX_Ready) begin
                    if (!empty) begin
                        pop     = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clk_S) begin
        if (Rst) begin
            state_q   <= RST_STATE;
            tx_vld_q  <= RST_VALID;
            tx_data_q <= '0;
            Pkts_Sent <= '0;
        end else begin
            state_q  <= state_d;
            tx_vld_q <= (state_d == LAUNCH);
            if (pop) begin
                tx_data_q <= head;
            end
            if (sent_inc) begin
                Pkts_Sent <= Pkts_Sent + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_tx_pkt_source.sv
// Directed self-checking bench for tx_pkt_source.
module tb_tx_pkt_source;
    localparam int W = 55;

    logic        clk;
    logic        rst;
    logic [2:0]  fifo_count;
    logic [15:0] pkts_sent;
    int          total;
    int          bad;

    tx_pkt_source_if #(.DATA_W(W)) bus ();

    tx_pkt_source #(
        .DATA_W (W),
        .DEPTH  (4),
        .ADDR_W (2),
        .CNT_W  (16)
    ) dut (
        .Clk_S      (clk),
        .Rst        (rst),
        .bus        (bus),
        .Fifo_Count (fifo_count),
        .Pkts_Sent  (pkts_sent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.In_Valid = 1'b0;
        bus.In_Data  = '0;
        bus.TX_Ready = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic push_pkt(input logic [W-1:0] d);
        bus.In_Valid = 1'b1;
        bus.In_Data  = d;
        step();
        bus.In_Valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.TX_Ready = 1'b1;
        bus.In_Valid = 1'b1;
        bus.In_Data  = 55'd7;
        for (int i = 0; i < 3; i++) begin
            step();
            total++; if (bus.In_Ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %0b want 0", bus.In_Ready); end
        end
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b want 0", bus.TX_Data_Valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        total++; if (pkts_sent !== 16'd0) begin bad++; $display("FAIL rst_sent: got %0d want 0", pkts_sent); end
        total++; if (bus.TX_Data !== 55'd0) begin bad++; $display("FAIL rst_data: got %0h want 0", bus.TX_Data); end
        bus.In_Valid = 1'b0;
        rst = 1'b0;
        #1;
        total++; if (bus.In_Ready !== 1'b1) begin bad++; $display("FAIL rel_in_ready: got %0b want 1", bus.In_Ready); end
        step();
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL rel_count: got %0d want 0", fifo_count); end
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL rel_valid: got %0b want 0", bus.TX_Data_Valid); end
    endtask

    task automatic test_single();
        do_reset();
        push_pkt(55'd3);
        total++; if (fifo_count !== 3'd1) begin bad++; $display("FAIL single_count1: got %0d want 1", fifo_count); end
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL single_early: got %0b want 0", bus.TX_Data_Valid); end
        step();
        total++; if (bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL single_valid: got %0b want 1", bus.TX_Data_Valid); end
        total++; if (bus.TX_Data !== 55'd3) begin bad++; $display("FAIL single_data: got %0h want 3", bus.TX_Data); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_count0: got %0d want 0", fifo_count); end
        bus.TX_Ready = 1'b0;
        step();
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL single_drop: got %0b want 0", bus.TX_Data_Valid); end
        total++; if (pkts_sent !== 16'd1) begin bad++; $display("FAIL single_sent: got %0d want 1", pkts_sent); end
        step();
        total++; if (bus.TX_Data !== 55'd3) begin bad++; $display("FAIL single_hold: got %0h want 3", bus.TX_Data); end
        total++; if (pkts_sent !== 16'd1) begin bad++; $display("FAIL single_sent_hold: got %0d want 1", pkts_sent); end
        bus.TX_Ready = 1'b1;
        step();
        step();
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL single_idle: got %0b want 0", bus.TX_Data_Valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL single_end_count: got %0d want 0", fifo_count); end
    endtask

    task automatic test_full();
        do_reset();
        bus.TX_Ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            push_pkt(55'(i));
            total++; if (fifo_count !== 3'(i)) begin bad++; $display("FAIL full_count%0d: got %0d want %0d", i, fifo_count, i); end
        end
        total++; if (bus.In_Ready !== 1'b0) begin bad++; $display("FAIL full_in_ready: got %0b want 0", bus.In_Ready); end
        push_pkt(55'd5);
        total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL full_overflow: got %0d want 4", fifo_count); end
        bus.TX_Ready = 1'b1;
        step();
        total++; if (bus.TX_Data !== 55'd1 || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL full_launch1: got %0h/%0b want 1/1", bus.TX_Data, bus.TX_Data_Valid); end
        for (int i = 2; i <= 4; i++) begin
            bus.TX_Ready = 1'b0;
            step();
            bus.TX_Ready = 1'b1;
            step();
            total++; if (bus.TX_Data !== 55'(i) || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL full_launch%0d: got %0h/%0b want %0d/1", i, bus.TX_Data, bus.TX_Data_Valid, i); end
        end
        bus.TX_Ready = 1'b0;
        step();
        bus.TX_Ready = 1'b1;
        step();
        step();
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL full_no5: got %0b want 0", bus.TX_Data_Valid); end
        total++; if (bus.TX_Data !== 55'd4) begin bad++; $display("FAIL full_last_data: got %0h want 4", bus.TX_Data); end
        total++; if (pkts_sent !== 16'd4) begin bad++; $display("FAIL full_sent: got %0d want 4", pkts_sent); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL full_drained: got %0d want 0", fifo_count); end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] a;
        logic [W-1:0] b;
        a = 55'h2AAAAAAAAAAAAA;
        b = 55'h15555555555555;
        do_reset();
        bus.TX_Ready = 1'b0;
        push_pkt(a);
        push_pkt(b);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL b2b_count: got %0d want 2", fifo_count); end
        bus.TX_Ready = 1'b1;
        step();
        total++; if (bus.TX_Data !== a || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL b2b_first: got %0h/%0b want %0h/1", bus.TX_Data, bus.TX_Data_Valid, a); end
        bus.TX_Ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            total++; if (bus.TX_Data_Valid !== 1'b0 || bus.TX_Data !== a) begin bad++; $display("FAIL b2b_busy1_%0d: got %0h/%0b want %0h/0", i, bus.TX_Data, bus.TX_Data_Valid, a); end
        end
        bus.TX_Ready = 1'b1;
        step();
        total++; if (bus.TX_Data !== b || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL b2b_second: got %0h/%0b want %0h/1", bus.TX_Data, bus.TX_Data_Valid, b); end
        bus.TX_Ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            step();
            total++; if (bus.TX_Data_Valid !== 1'b0 || bus.TX_Data !== b) begin bad++; $display("FAIL b2b_busy2_%0d: got %0h/%0b want %0h/0", i, bus.TX_Data, bus.TX_Data_Valid, b); end
        end
        total++; if (pkts_sent !== 16'd2) begin bad++; $display("FAIL b2b_sent: got %0d want 2", pkts_sent); end
        bus.TX_Ready = 1'b1;
        step();
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL b2b_idle: got %0b want 0", bus.TX_Data_Valid); end
    endtask

    task automatic test_push_pop();
        do_reset();
        bus.TX_Ready = 1'b0;
        push_pkt(55'd10);
        push_pkt(55'd11);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_pre: got %0d want 2", fifo_count); end
        bus.TX_Ready = 1'b1;
        push_pkt(55'd12);
        total++; if (fifo_count !== 3'd2) begin bad++; $display("FAIL pp_count: got %0d want 2", fifo_count); end
        total++; if (bus.TX_Data !== 55'd10 || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL pp_launch10: got %0h/%0b want a/1", bus.TX_Data, bus.TX_Data_Valid); end
        for (int i = 11; i <= 12; i++) begin
            bus.TX_Ready = 1'b0;
            step();
            bus.TX_Ready = 1'b1;
            step();
            total++; if (bus.TX_Data !== 55'(i) || bus.TX_Data_Valid !== 1'b1) begin bad++; $display("FAIL pp_launch%0d: got %0h/%0b want %0h/1", i, bus.TX_Data, bus.TX_Data_Valid, i); end
            total++; if (fifo_count !== 3'(12 - i)) begin bad++; $display("FAIL pp_count%0d: got %0d want %0d", i, fifo_count, 12 - i); end
        end
        bus.TX_Ready = 1'b0;
        step();
        total++; if (pkts_sent !== 16'd3) begin bad++; $display("FAIL pp_sent: got %0d want 3", pkts_sent); end
        bus.TX_Ready = 1'b1;
        step();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.TX_Ready = 1'b0;
        for (int i = 21; i <= 24; i++) push_pkt(55'(i));
        bus.TX_Ready = 1'b1;
        step();
        total++; if (bus.TX_Data !== 55'd21 || fifo_count !== 3'd3) begin bad++; $display("FAIL mid_launch: got %0h/%0d want 15/3", bus.TX_Data, fifo_count); end
        bus.TX_Ready = 1'b0;
        step();
        total++; if (bus.TX_Data_Valid !== 1'b0 || pkts_sent !== 16'd1) begin bad++; $display("FAIL mid_busy: got %0b/%0d want 0/1", bus.TX_Data_Valid, pkts_sent); end
        rst = 1'b1;
        #1;
        total++; if (bus.In_Ready !== 1'b0) begin bad++; $display("FAIL mid_in_ready: got %0b want 0", bus.In_Ready); end
        step();
        rst = 1'b0;
        total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %0b want 0", bus.TX_Data_Valid); end
        total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL mid_count: got %0d want 0", fifo_count); end
        total++; if (pkts_sent !== 16'd0 || bus.TX_Data !== 55'd0) begin bad++; $display("FAIL mid_clear: got %0d/%0h want 0/0", pkts_sent, bus.TX_Data); end
        bus.TX_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            total++; if (bus.TX_Data_Valid !== 1'b0) begin bad++; $display("FAIL mid_nolaunch%0d: got %0b want 0", i, bus.TX_Data_Valid); end
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.In_Valid = 1'b0;
        bus.In_Data  = '0;
        bus.TX_Ready = 1'b1;
        test_reset();
        test_single();
        test_full();
        test_back_to_back();
        test_push_pop();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tx_pkt_source.md
Name: tx_pkt_source

Overview:
- Host-side packet source that feeds the serial transmitter's parallel handshake (TX_Data / TX_Data_Valid / TX_Ready).
- Buffers 55-bit router packets from the core in a small FIFO.
- Launches packets one at a time and holds each stable until the transmitter reports completion.
- Sits between the router core output port and the transmitter, in the Clk_S domain.

Parameters:
- DATA_W, 55: packet width; must match the transmitter's TX_Data width.
- DEPTH, 4: FIFO entries; must be a power of 2, at least 2.
- ADDR_W, 2: log2(DEPTH).
- CNT_W, 16: width of the sent-packet counter.

Ports:
- Clk_S  in  1  system clock; all logic is on the rising edge.
- Rst  in  1  reset, synchronous, active-high.
- In_Data  in  DATA_W  packet from the router core.
- In_Valid  in  1  In_Data is valid.
- In_Ready  out  1  FIFO can accept a packet.
- TX_Ready  in  1  transmitter is idle (high) or busy (low).
- TX_Data  out  DATA_W  packet to the transmitter; registered.
- TX_Data_Valid  out  1  launch request to the transmitter; registered.
- Fifo_Count  out  ADDR_W+1  number of buffered packets, 0..DEPTH.
- Pkts_Sent  out  CNT_W  packets accepted by the transmitter; wraps modulo 2^CNT_W.

Behaviour:
- Reset (Rst high at an edge):
  - TX_Data=0, TX_Data_Valid=0, Fifo_Count=0, Pkts_Sent=0, state=IDLE.
  - FIFO pointers cleared; buffered packets are discarded.
  - In_Ready=0 while Rst is high, combinationally.
- In_Ready = !Rst && (Fifo_Count != DEPTH). It never depends on In_Valid.
- Push: In_Valid && In_Ready at an edge writes In_Data at wr_ptr, then wr_ptr+1 mod DEPTH. In_Valid while full is ignored and nothing is lost from the FIFO.
- Pop: happens only on a launch transition. The head is copied into the TX_Data register and rd_ptr+1 mod DEPTH.
- Simultaneous push and pop: both happen and Fifo_Count is unchanged. A push into a full FIFO is never allowed, even when a pop occurs in the same cycle.
- FSM states: IDLE, LAUNCH, BUSY.
  - IDLE: if Fifo_Count != 0 && TX_Ready, pop and go to LAUNCH. TX_Data_Valid goes 1 after this edge.
  - LAUNCH: TX_Data_Valid=1. When TX_Ready is sampled 0: TX_Data_Valid goes 0, Pkts_Sent+1, go to BUSY. Otherwise stay; there is no timeout.
  - BUSY: TX_Data_Valid=0 and TX_Data held. When TX_Ready is sampled 1:
    - if Fifo_Count != 0, pop and go to LAUNCH (back-to-back, no idle cycle);
    - else go to IDLE.
- TX_Data changes only on launch transitions. It is stable from launch through the end of BUSY.
- Latency: push into an empty FIFO at edge k, with TX_Ready=1, gives TX_Data/TX_Data_Valid valid after edge k+1.
- A push in the same cycle as the launch of another packet is legal.
- An empty FIFO means no launch.
- A TX_Ready glitch is seen only at sampled edges. A 1-cycle low pulse during LAUNCH counts as acceptance.
- Reset mid-transmission (LAUNCH or BUSY): return to IDLE on the reset edge, TX_Data_Valid=0, and the in-flight and buffered packets are dropped. The transmitter is reset separately.

Decomposition:
- Shared package holds:
  - PKT_W=55, matching the transmitter and receiver;
  - the state enum (IDLE=2'd0, LAUNCH=2'd1, BUSY=2'd2);
  - the reset-value constants.
- One sub-module, pkt_fifo: a synchronous DEPTH x DATA_W FIFO with push, pop, head, count, full, empty, and synchronous active-high reset.
- The FSM, TX_Data register and counter stay in tx_pkt_source.

Test Plan:
1. Reset: hold Rst high 3 cycles with In_Valid=1 -> In_Ready=0, TX_Data_Valid=0, Fifo_Count=0, Pkts_Sent=0. Release Rst -> In_Ready=1, and nothing was written.
2. Single packet: push 55'd3 with TX_Ready=1 -> TX_Data=55'd3 and TX_Data_Valid=1 one edge later. Drive TX_Ready low -> TX_Data_Valid=0 next edge, Pkts_Sent=1, TX_Data still 3. Raise TX_Ready -> IDLE, Fifo_Count=0.
3. Full FIFO: with TX_Ready=0, push 5 packets (55'd1..55'd5) -> Fifo_Count=4, In_Ready=0, and 55'd5 is not stored. Then release TX_Ready -> 1,2,3,4 are launched in order.
4. Back-to-back: queue 55'h2AAAAAAAAAAAAA and 55'h15555555555555, then model the transmitter as 60 cycles busy each -> second launch is on the same edge TX_Ready returns high. Pkts_Sent=2, with no idle cycle between.
5. Simultaneous push and pop: Fifo_Count=2 and the launch edge coincides with In_Valid -> Fifo_Count stays 2, and FIFO order is preserved.
6. Reset mid-transmission: in BUSY with 3 packets queued, pulse Rst for 1 cycle -> TX_Data_Valid=0, Fifo_Count=0, state IDLE. No launch follows even when TX_Ready=1.
